// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multiply EXE occupancy, data-memory
// freezes and taken-branch flushes, plus a memory-wait watchdog and stall counter.
`timescale 1ns/1ps
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_reg1_read,
  input  logic        id_reg2_read,
  input  logic        id_sw_read,
  input  logic [4:0]  id_reg1_addr,
  input  logic [4:0]  id_reg2_addr,
  input  logic [4:0]  id_sw_addr,
  input  logic        exe_DM_read,
  input  logic        exe_reg_write,
  input  logic [4:0]  exe_write_addr,
  input  logic        exe_mul_start,
  input  logic        mem_DM_req,
  input  logic        dm_ready,
  input  logic        id_branch_taken,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_exe,
  output logic        stall_exe_mem,
  output logic        bubble_id_exe,
  output logic        bubble_exe_mem,
  output logic        bubble_mem_wb,
  output logic        flush_if_id,
  output logic        mul_busy,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, MUL = 1'b1} state_t;

  localparam logic [3:0] MCNT_INIT = 4'(MUL_CYCLES - 1);
  localparam logic [7:0] WD_LAST   = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  mcnt_q, mcnt_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic freeze;
  logic lu_hazard;
  logic src_hit;

  assign freeze = mem_DM_req & ~dm_ready;

  // Register 0 is compared like any other register.
  assign src_hit = (id_reg1_read & (id_reg1_addr == exe_write_addr))
                 | (id_reg2_read & (id_reg2_addr == exe_write_addr))
                 | (id_sw_read   & (id_sw_addr   == exe_write_addr));
  assign lu_hazard = exe_DM_read & exe_reg_write & src_hit;

  always_comb begin
    state_d        = state_q;
    mcnt_d         = mcnt_q;
    stall_pc       = 1'b0;
    stall_if_id    = 1'b0;
    stall_id_exe   = 1'b0;
    stall_exe_mem  = 1'b0;
    bubble_id_exe  = 1'b0;
    bubble_exe_mem = 1'b0;
    bubble_mem_wb  = 1'b0;
    flush_if_id    = 1'b0;

    if (freeze) begin
      stall_pc      = 1'b1;
      stall_if_id   = 1'b1;
      stall_id_exe  = 1'b1;
      stall_exe_mem = 1'b1;
      bubble_mem_wb = 1'b1;
    end else if (state_q == RUN && exe_mul_start) begin
      stall_pc       = 1'b1;
      stall_if_id    = 1'b1;
      stall_id_exe   = 1'b1;
      bubble_exe_mem = 1'b1;
      state_d        = MUL;
      mcnt_d         = MCNT_INIT;
    end else if (state_q == MUL && mcnt_q > 4'd1) begin
      stall_pc       = 1'b1;
      stall_if_id    = 1'b1;
      stall_id_exe   = 1'b1;
      bubble_exe_mem = 1'b1;
      mcnt_d         = mcnt_q - 4'd1;
    end else begin
      // Last multiply cycle behaves like RUN: the result advances this cycle.
      if (state_q == MUL) begin
        state_d = RUN;
        mcnt_d  = 4'd0;
      end
      if (lu_hazard) begin
        stall_pc      = 1'b1;
        stall_if_id   = 1'b1;
        bubble_id_exe = 1'b1;
      end else if (id_branch_taken) begin
        flush_if_id = 1'b1;
      end
    end
  end

  always_comb begin
    wcnt_d        = 8'd0;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d   = stall_cnt_q;
    if (freeze) begin
      wcnt_d = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
      if (wcnt_q == WD_LAST) mem_timeout_d = 1'b1;
    end
    if (stall_pc && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      mcnt_q        <= 4'd0;
      wcnt_q        <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      mcnt_q        <= mcnt_d;
      wcnt_q        <= wcnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign mul_busy    = (state_q == MUL);
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven bench for hazard_ctrl with a scoreboard queue of expected outputs.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_reg1_read = 0, id_reg2_read = 0, id_sw_read = 0;
  logic [4:0] id_reg1_addr = 0, id_reg2_addr = 0, id_sw_addr = 0;
  logic exe_DM_read = 0, exe_reg_write = 0;
  logic [4:0] exe_write_addr = 0;
  logic exe_mul_start = 0, mem_DM_req = 0, dm_ready = 0, id_branch_taken = 0;
  logic stall_pc, stall_if_id, stall_id_exe, stall_exe_mem;
  logic bubble_id_exe, bubble_exe_mem, bubble_mem_wb, flush_if_id;
  logic mul_busy, mem_timeout;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_CYCLES(4), .TIMEOUT(3)) dut (
    .clk(clk), .rst(rst),
    .id_reg1_read(id_reg1_read), .id_reg2_read(id_reg2_read), .id_sw_read(id_sw_read),
    .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr), .id_sw_addr(id_sw_addr),
    .exe_DM_read(exe_DM_read), .exe_reg_write(exe_reg_write), .exe_write_addr(exe_write_addr),
    .exe_mul_start(exe_mul_start), .mem_DM_req(mem_DM_req), .dm_ready(dm_ready),
    .id_branch_taken(id_branch_taken),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_exe(stall_id_exe),
    .stall_exe_mem(stall_exe_mem), .bubble_id_exe(bubble_id_exe),
    .bubble_exe_mem(bubble_exe_mem), .bubble_mem_wb(bubble_mem_wb),
    .flush_if_id(flush_if_id), .mul_busy(mul_busy), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt)
  );

  // {stall_pc, stall_if_id, stall_id_exe, stall_exe_mem,
  //  bubble_id_exe, bubble_exe_mem, bubble_mem_wb, flush_if_id, mul_busy, mem_timeout}
  logic [9:0] got;
  assign got = {stall_pc, stall_if_id, stall_id_exe, stall_exe_mem, bubble_id_exe,
                bubble_exe_mem, bubble_mem_wb, flush_if_id, mul_busy, mem_timeout};

  localparam logic [9:0] NONE = 10'h000;
  localparam logic [9:0] LU   = 10'h320;
  localparam logic [9:0] MULS = 10'h390;
  localparam logic [9:0] FRZ  = 10'h3C8;
  localparam logic [9:0] FL   = 10'h004;
  localparam logic [9:0] BUSY = 10'h002;
  localparam logic [9:0] TO   = 10'h001;

  typedef struct {
    string      name;
    logic [2:0] rd;
    logic [4:0] a1, a2, as;
    logic       ld, rw;
    logic [4:0] wa;
    logic       ms, mreq, rdy, br;
    logic [9:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [9:0]  exp_q[$];
  logic [15:0] cnt_q[$];
  logic [15:0] cnt_model = 16'd0;
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(string n, logic [2:0] rd, logic [4:0] a1, logic [4:0] a2,
                              logic [4:0] as, logic ld, logic rw, logic [4:0] wa, logic ms,
                              logic mreq, logic rdy, logic br, logic [9:0] e);
    vec_t v;
    v.name = n; v.rd = rd; v.a1 = a1; v.a2 = a2; v.as = as; v.ld = ld; v.rw = rw;
    v.wa = wa; v.ms = ms; v.mreq = mreq; v.rdy = rdy; v.br = br; v.exp = e;
    return v;
  endfunction

  task automatic chk_outs(string n, logic [9:0] e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s outputs got %b want %b", n, got, e);
    end
  endtask

  task automatic chk_cnt(string n, logic [15:0] e);
    checks++;
    if (stall_cnt !== e) begin
      errors++;
      $display("FAIL %s stall_cnt got %0d want %0d", n, stall_cnt, e);
    end
  endtask

  task automatic drive_idle();
    {id_reg1_read, id_reg2_read, id_sw_read} = 3'b000;
    id_reg1_addr = 0; id_reg2_addr = 0; id_sw_addr = 0;
    exe_DM_read = 0; exe_reg_write = 0; exe_write_addr = 0;
    exe_mul_start = 0; mem_DM_req = 0; dm_ready = 0; id_branch_taken = 0;
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    {id_reg1_read, id_reg2_read, id_sw_read} = v.rd;
    id_reg1_addr = v.a1; id_reg2_addr = v.a2; id_sw_addr = v.as;
    exe_DM_read = v.ld; exe_reg_write = v.rw; exe_write_addr = v.wa;
    exe_mul_start = v.ms; mem_DM_req = v.mreq; dm_ready = v.rdy; id_branch_taken = v.br;
    exp_q.push_back(v.exp);
    cnt_q.push_back(cnt_model);
    @(negedge clk);
    chk_outs(v.name, exp_q.pop_front());
    chk_cnt(v.name, cnt_q.pop_front());
    if (v.exp[9] && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle;
    idle = mk("idle", 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);

    tbl.push_back(idle);
    tbl.push_back(mk("lu_reg2",      3'b010, 0, 5, 0, 1, 1, 5, 0, 0, 0, 0, LU));
    tbl.push_back(mk("lu_after",     3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
    tbl.push_back(mk("lu_reg1",      3'b100, 7, 0, 0, 1, 1, 7, 0, 0, 0, 0, LU));
    tbl.push_back(mk("lu_sw_r0",     3'b001, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, LU));
    tbl.push_back(mk("no_lu_disen",  3'b010, 9, 3, 0, 1, 1, 9, 0, 0, 0, 0, NONE));
    tbl.push_back(mk("no_lu_nowr",   3'b100, 4, 0, 0, 1, 0, 4, 0, 0, 0, 0, NONE));
    tbl.push_back(mk("no_lu_noload", 3'b100, 4, 0, 0, 0, 1, 4, 0, 0, 0, 0, NONE));
    tbl.push_back(mk("branch",       3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FL));
    tbl.push_back(mk("branch_lu",    3'b010, 0, 6, 0, 1, 1, 6, 0, 0, 0, 1, LU));
    tbl.push_back(mk("branch_defer", 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FL));
    tbl.push_back(mk("mul_start",    3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MULS));
    tbl.push_back(mk("mul_m3",       3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MULS | BUSY));
    tbl.push_back(mk("mul_m2_reply", 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MULS | BUSY));
    tbl.push_back(mk("mul_m1_br",    3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, FL | BUSY));
    tbl.push_back(mk("mul_done",     3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
    tbl.push_back(mk("mul_frz_st",   3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, FRZ));
    tbl.push_back(mk("mul_restart",  3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, MULS));
    tbl.push_back(mk("mulf_m3",      3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MULS | BUSY));
    tbl.push_back(mk("mulf_frz1",    3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ | BUSY));
    tbl.push_back(mk("mulf_frz2",    3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ | BUSY));
    tbl.push_back(mk("mulf_m2",      3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, MULS | BUSY));
    tbl.push_back(mk("mulf_m1_lu",   3'b100, 8, 0, 0, 1, 1, 8, 0, 0, 0, 0, LU | BUSY));
    tbl.push_back(idle);
    tbl.push_back(mk("wd_frz1",      3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ));
    tbl.push_back(mk("wd_frz2",      3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ));
    tbl.push_back(mk("wd_frz3",      3'b000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, FRZ));
    tbl.push_back(mk("wd_sticky",    3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, TO));
    tbl.push_back(mk("wd_sticky_lu", 3'b010, 0, 2, 0, 1, 1, 2, 0, 0, 0, 0, LU | TO));
    tbl.push_back(mk("rm_start",     3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MULS | TO));
    tbl.push_back(mk("rm_m3",        3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MULS | BUSY | TO));

    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    chk_outs("reset", NONE);
    chk_cnt("reset", 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Asynchronous reset in the middle of a multiply abandons it at once.
    drive_idle();
    #2 rst = 1'b1;
    #1;
    chk_outs("reset_mid_mul", NONE);
    chk_cnt("reset_mid_mul", 16'd0);
    cnt_model = 16'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    apply(idle);
    apply(mk("post_rst_mul", 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, MULS));
    apply(mk("post_rst_m3",  3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MULS | BUSY));
    apply(mk("post_rst_m2",  3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, MULS | BUSY));
    apply(mk("post_rst_m1",  3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BUSY));
    apply(idle);

    // Long freeze saturates the stall counter and trips the watchdog.
    @(posedge clk); #1;
    mem_DM_req = 1'b1; dm_ready = 1'b0;
    repeat (65600) @(posedge clk);
    @(negedge clk);
    chk_outs("sat_freeze", FRZ | TO);
    chk_cnt("saturation", 16'hFFFF);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk_outs("sat_release", TO);
    chk_cnt("sat_hold", 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
